// File: rtl/commit_trace_buffer_if.sv
// ---------------------------------------------------------------------------
// commit_trace_buffer_if
//
// Purpose:
//   Bundles the multi-lane commit input side and the single-lane trace output
//   side of commit_trace_buffer into one interface.
//
// Modports:
//   slave  - used by commit_trace_buffer (takes commit lanes, drives trace).
//   master - used by the producer/consumer environment.
//
// Signals:
//   in_valid      [COMMIT_WIDTH]       per-lane commit valid, bit i = lane i
//   in_pc         [COMMIT_WIDTH*XLEN]  lane i at [i*XLEN +: XLEN]
//   in_rf_wnum    [COMMIT_WIDTH*5]     lane i at [i*5 +: 5], 0 = no rf write
//   in_rf_wdata   [COMMIT_WIDTH*XLEN]  lane i at [i*XLEN +: XLEN]
//   in_ready      1                    room for a full group this cycle
//   out_valid     1                    head record available
//   out_ready     1                    consumer takes the head record
//   out_pc / out_rf_wnum / out_rf_wdata  head record fields
//   count         $clog2(DEPTH)+1      current occupancy
//   overflow      1                    sticky: a valid group was dropped
//
// Optional macro COMMIT_TRACE_SRAM_EN adds the per-lane sram write fields
// (in_sram_wen/waddr/wdata) and their head-record outputs.
// ---------------------------------------------------------------------------
interface commit_trace_buffer_if #(
  parameter int COMMIT_WIDTH = 2,
  parameter int DEPTH        = 16,
  parameter int XLEN         = 64
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [COMMIT_WIDTH-1:0]      in_valid;
  logic [COMMIT_WIDTH*XLEN-1:0] in_pc;
  logic [COMMIT_WIDTH*5-1:0]    in_rf_wnum;
  logic [COMMIT_WIDTH*XLEN-1:0] in_rf_wdata;
  logic                         in_ready;

  logic                         out_valid;
  logic                         out_ready;
  logic [XLEN-1:0]              out_pc;
  logic [4:0]                   out_rf_wnum;
  logic [XLEN-1:0]              out_rf_wdata;

  logic [CNT_W-1:0]             count;
  logic                         overflow;

`ifdef COMMIT_TRACE_SRAM_EN
  logic [COMMIT_WIDTH*8-1:0]    in_sram_wen;
  logic [COMMIT_WIDTH*32-1:0]   in_sram_waddr;
  logic [COMMIT_WIDTH*64-1:0]   in_sram_wdata;
  logic [7:0]                   out_sram_wen;
  logic [31:0]                  out_sram_waddr;
  logic [63:0]                  out_sram_wdata;

  modport slave (
    input  in_valid, in_pc, in_rf_wnum, in_rf_wdata, out_ready,
    input  in_sram_wen, in_sram_waddr, in_sram_wdata,
    output in_ready, out_valid, out_pc, out_rf_wnum, out_rf_wdata,
    output count, overflow,
    output out_sram_wen, out_sram_waddr, out_sram_wdata
  );

  modport master (
    output in_valid, in_pc, in_rf_wnum, in_rf_wdata, out_ready,
    output in_sram_wen, in_sram_waddr, in_sram_wdata,
    input  in_ready, out_valid, out_pc, out_rf_wnum, out_rf_wdata,
    input  count, overflow,
    input  out_sram_wen, out_sram_waddr, out_sram_wdata
  );
`else
  modport slave (
    input  in_valid, in_pc, in_rf_wnum, in_rf_wdata, out_ready,
    output in_ready, out_valid, out_pc, out_rf_wnum, out_rf_wdata,
    output count, overflow
  );

  modport master (
    output in_valid, in_pc, in_rf_wnum, in_rf_wdata, out_ready,
    input  in_ready, out_valid, out_pc, out_rf_wnum, out_rf_wdata,
    input  count, overflow
  );
`endif

endinterface

// File: rtl/commit_trace_buffer.sv
// ---------------------------------------------------------------------------
// commit_trace_buffer
//
// Purpose:
//   Collects up to COMMIT_WIDTH commit records per cycle from a superscalar
//   core, compacts the valid lanes in ascending lane order, buffers them in a
//   DEPTH-entry FIFO and drains one record per handshake to a single-lane
//   trace consumer (first-word-fall-through).
//
// Ports:
//   clock  - sole clock, rising edge
//   reset  - synchronous, active-low
//   bus    - commit_trace_buffer_if.slave (commit lanes in, trace out,
//            occupancy count and sticky overflow flag)
//
// Behaviour notes:
//   - A group is accepted only whole: in_ready requires room for
//     COMMIT_WIDTH records, based on the registered count alone, so there is
//     no combinational path from out_ready to in_ready.
//   - A valid group arriving while in_ready is low is dropped entirely and
//     sets overflow, which stays set until reset.
//   - A pushed record shows on the output one cycle later at the earliest.
//
// Configuration:
//   COMMIT_TRACE_SRAM_EN - when defined, the per-lane sram write fields are
//   stored alongside each record and presented with the head record.
// ---------------------------------------------------------------------------
module commit_trace_buffer #(
  parameter int COMMIT_WIDTH = 2,
  parameter int DEPTH        = 16,
  parameter int XLEN         = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  commit_trace_buffer_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(COMMIT_WIDTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  // Entry storage (not cleared by reset; only the pointers are).
  logic [XLEN-1:0]  r_pc_mem    [DEPTH];
  logic [4:0]       r_wnum_mem  [DEPTH];
  logic [XLEN-1:0]  r_wdata_mem [DEPTH];
`ifdef COMMIT_TRACE_SRAM_EN
  logic [7:0]       r_sram_wen_mem   [DEPTH];
  logic [31:0]      r_sram_waddr_mem [DEPTH];
  logic [63:0]      r_sram_wdata_mem [DEPTH];
`endif

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  logic             w_any_valid;
  logic             w_in_ready;
  logic             w_push;
  logic             w_drop;
  logic             w_out_valid;
  logic             w_pop;
  logic [CNT_W-1:0] w_free;
  logic [CNT_W-1:0] w_npush;
  logic [CNT_W-1:0] w_push_cnt;
  logic [CNT_W-1:0] w_pop_cnt;
  logic [CNT_W-1:0] w_count_next;
  logic [PTR_W-1:0] w_lane_addr [COMMIT_WIDTH];

  // Free space and acceptance decision, from registered occupancy only.
  always_comb begin
    w_free      = DEPTH_C - r_count;
    w_in_ready  = (w_free >= WIDTH_C);
    w_any_valid = |bus.in_valid;
    w_push      = w_in_ready & w_any_valid;
    w_drop      = w_any_valid & ~w_in_ready;
    w_out_valid = (r_count != {CNT_W{1'b0}});
    w_pop       = w_out_valid & bus.out_ready;
  end

  // Lane compaction: each valid lane lands at wr_ptr plus the number of
  // valid lanes below it; the running total is the group's push count.
  // Address arithmetic is PTR_W wide so a group may straddle the wrap.
  always_comb begin
    w_npush = {CNT_W{1'b0}};
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      w_lane_addr[i] = r_wr_ptr + w_npush[PTR_W-1:0];
      w_npush        = w_npush + {{(CNT_W-1){1'b0}}, bus.in_valid[i]};
    end
  end

  // Next occupancy; push and pop in the same cycle are both honoured.
  always_comb begin
    if (w_push) begin
      w_push_cnt = w_npush;
    end else begin
      w_push_cnt = {CNT_W{1'b0}};
    end
    if (w_pop) begin
      w_pop_cnt = ONE_C;
    end else begin
      w_pop_cnt = {CNT_W{1'b0}};
    end
    w_count_next = r_count + w_push_cnt - w_pop_cnt;
  end

  // Entry write: valid lanes of an accepted group, never during reset.
  always_ff @(posedge clock) begin
    if (reset && w_push) begin
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
        if (bus.in_valid[i]) begin
          r_pc_mem[w_lane_addr[i]]    <= bus.in_pc[i*XLEN +: XLEN];
          r_wnum_mem[w_lane_addr[i]]  <= bus.in_rf_wnum[i*5 +: 5];
          r_wdata_mem[w_lane_addr[i]] <= bus.in_rf_wdata[i*XLEN +: XLEN];
`ifdef COMMIT_TRACE_SRAM_EN
          r_sram_wen_mem[w_lane_addr[i]]   <= bus.in_sram_wen[i*8 +: 8];
          r_sram_waddr_mem[w_lane_addr[i]] <= bus.in_sram_waddr[i*32 +: 32];
          r_sram_wdata_mem[w_lane_addr[i]] <= bus.in_sram_wdata[i*64 +: 64];
`endif
        end
      end
    end
  end

  // Pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr   <= {PTR_W{1'b0}};
      r_rd_ptr   <= {PTR_W{1'b0}};
      r_count    <= {CNT_W{1'b0}};
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + w_npush[PTR_W-1:0];
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_count    <= w_count_next;
      r_overflow <= r_overflow | w_drop;
    end
  end

  // Head record is read straight from storage (first-word-fall-through);
  // it only moves when rd_ptr advances, so it holds while stalled.
  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = w_out_valid;
  assign bus.out_pc       = r_pc_mem[r_rd_ptr];
  assign bus.out_rf_wnum  = r_wnum_mem[r_rd_ptr];
  assign bus.out_rf_wdata = r_wdata_mem[r_rd_ptr];
  assign bus.count        = r_count;
  assign bus.overflow     = r_overflow;
`ifdef COMMIT_TRACE_SRAM_EN
  assign bus.out_sram_wen   = r_sram_wen_mem[r_rd_ptr];
  assign bus.out_sram_waddr = r_sram_waddr_mem[r_rd_ptr];
  assign bus.out_sram_wdata = r_sram_wdata_mem[r_rd_ptr];
`endif

endmodule

// File: tb/tb_commit_trace_buffer.sv
// ---------------------------------------------------------------------------
// tb_commit_trace_buffer
//
// Self-checking bench for commit_trace_buffer (COMMIT_WIDTH=2, DEPTH=16,
// XLEN=64). A queue-based reference model tracks the buffered records,
// the sticky overflow flag and acceptance; every cycle the DUT is compared
// against it. Directed table vectors and hand-written sequences cover the
// reset, sparse-lane, full/overflow, steady-state wrap and mid-run reset
// cases, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_commit_trace_buffer;

  localparam int W     = 2;
  localparam int DEPTH = 16;
  localparam int XLEN  = 64;

  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  wn;
    logic [63:0] wd;
  } rec_t;

  typedef struct {
    logic [1:0]  v;
    logic [63:0] pc0;
    logic [63:0] pc1;
    logic        ordy;
    logic        e_valid;
    int          e_count;
    logic [63:0] e_pc;
  } vec_t;

  logic clk;
  logic rst_n;

  commit_trace_buffer_if #(.COMMIT_WIDTH(W), .DEPTH(DEPTH), .XLEN(XLEN)) bus ();

  commit_trace_buffer #(.COMMIT_WIDTH(W), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rec_t q[$];
  logic m_ovf;
  int   n_checks;
  int   n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic compare_model();
    chk("count", 64'(bus.count), 64'(q.size()));
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    chk("in_ready", 64'(bus.in_ready), 64'((DEPTH - q.size()) >= W));
    chk("overflow", 64'(bus.overflow), 64'(m_ovf));
    if (q.size() != 0) begin
      chk("out_pc", bus.out_pc, q[0].pc);
      chk("out_rf_wnum", 64'(bus.out_rf_wnum), 64'(q[0].wn));
      chk("out_rf_wdata", bus.out_rf_wdata, q[0].wd);
    end
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare.
  task automatic step(input logic rst_v, input logic [1:0] v,
                      input logic [63:0] pc0, input logic [63:0] pc1,
                      input logic ordy);
    rec_t r0;
    rec_t r1;
    logic rdy;
    r0.pc = pc0; r0.wn = 5'($urandom); r0.wd = {$urandom, $urandom};
    r1.pc = pc1; r1.wn = 5'($urandom); r1.wd = {$urandom, $urandom};
    rst_n           = rst_v;
    bus.in_valid    = v;
    bus.in_pc       = {r1.pc, r0.pc};
    bus.in_rf_wnum  = {r1.wn, r0.wn};
    bus.in_rf_wdata = {r1.wd, r0.wd};
    bus.out_ready   = ordy;
    @(posedge clk);
    #1;
    if (!rst_v) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      rdy = ((DEPTH - q.size()) >= W);
      if (q.size() != 0 && ordy) begin
        void'(q.pop_front());
      end
      if (v != 2'b00) begin
        if (rdy) begin
          if (v[0]) q.push_back(r0);
          if (v[1]) q.push_back(r1);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    compare_model();
  endtask

  vec_t tbl [8];

  initial begin
    logic [63:0] pc_n;
    logic [1:0]  rv;
    n_checks = 0;
    n_fail   = 0;
    m_ovf    = 1'b0;
    rst_n    = 1'b0;
    bus.in_valid    = '0;
    bus.in_pc       = '0;
    bus.in_rf_wnum  = '0;
    bus.in_rf_wdata = '0;
    bus.out_ready   = 1'b0;
`ifdef COMMIT_TRACE_SRAM_EN
    bus.in_sram_wen   = '0;
    bus.in_sram_waddr = '0;
    bus.in_sram_wdata = '0;
`endif

    // Directed vectors: full group, drain, sparse lanes, idle out_ready.
    tbl[0] = '{2'b11, 64'h8000_0000, 64'h8000_0004, 1'b0, 1'b1, 2, 64'h8000_0000};
    tbl[1] = '{2'b00, 64'h0,         64'h0,         1'b1, 1'b1, 1, 64'h8000_0004};
    tbl[2] = '{2'b00, 64'h0,         64'h0,         1'b1, 1'b0, 0, 64'h0};
    tbl[3] = '{2'b10, 64'h0,         64'h1000,      1'b0, 1'b1, 1, 64'h1000};
    tbl[4] = '{2'b01, 64'h2000,      64'h0,         1'b0, 1'b1, 2, 64'h1000};
    tbl[5] = '{2'b00, 64'h0,         64'h0,         1'b1, 1'b1, 1, 64'h2000};
    tbl[6] = '{2'b00, 64'h0,         64'h0,         1'b1, 1'b0, 0, 64'h0};
    tbl[7] = '{2'b00, 64'h0,         64'h0,         1'b1, 1'b0, 0, 64'h0};

    // Reset and idle with out_ready held high.
    for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 64'h0, 64'h0, 1'b0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_count", 64'(bus.count), 64'h0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'h1);
    chk("rst_overflow", 64'(bus.overflow), 64'h0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 2'b00, 64'h0, 64'h0, 1'b1);
      chk("idle_count", 64'(bus.count), 64'h0);
    end

    // Table-driven directed sequence.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, tbl[i].v, tbl[i].pc0, tbl[i].pc1, tbl[i].ordy);
      chk("tbl_valid", 64'(bus.out_valid), 64'(tbl[i].e_valid));
      chk("tbl_count", 64'(bus.count), 64'(tbl[i].e_count));
      if (tbl[i].e_valid) chk("tbl_pc", bus.out_pc, tbl[i].e_pc);
    end

    // Fill to DEPTH, overflow on a further group, drain in order.
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 2'b11, 64'h100 + 64'(8*k), 64'h104 + 64'(8*k), 1'b0);
    end
    chk("full_count", 64'(bus.count), 64'd16);
    chk("full_in_ready", 64'(bus.in_ready), 64'h0);
    step(1'b1, 2'b01, 64'hdead, 64'h0, 1'b0);
    chk("ovf_flag", 64'(bus.overflow), 64'h1);
    chk("ovf_count", 64'(bus.count), 64'd16);
    for (int k = 0; k < 16; k++) begin
      chk("drain_pc", bus.out_pc, 64'h100 + 64'(4*k));
      step(1'b1, 2'b00, 64'h0, 64'h0, 1'b1);
    end
    chk("drain_empty", 64'(bus.out_valid), 64'h0);
    chk("ovf_sticky", 64'(bus.overflow), 64'h1);
    step(1'b0, 2'b00, 64'h0, 64'h0, 1'b0);
    chk("ovf_cleared", 64'(bus.overflow), 64'h0);

    // Steady state: one record per cycle across pointer wrap.
    pc_n = 64'h5000;
    for (int k = 0; k < 40; k++) begin
      rv = ($urandom_range(1) == 0) ? 2'b01 : 2'b10;
      step(1'b1, rv, pc_n, pc_n, 1'b1);
      chk("steady_count_le1", 64'(bus.count <= 1), 64'h1);
      chk("steady_pc", bus.out_pc, pc_n);
      pc_n = pc_n + 64'd4;
    end
    chk("steady_no_ovf", 64'(bus.overflow), 64'h0);
    step(1'b1, 2'b00, 64'h0, 64'h0, 1'b1);

    // Mid-run reset at count 14 while pushing and popping.
    for (int k = 0; k < 7; k++) begin
      step(1'b1, 2'b11, 64'h700 + 64'(k), 64'h780 + 64'(k), 1'b0);
    end
    chk("pre_rst_count", 64'(bus.count), 64'd14);
    step(1'b0, 2'b11, 64'h11, 64'h22, 1'b1);
    chk("midrst_count", 64'(bus.count), 64'h0);
    chk("midrst_valid", 64'(bus.out_valid), 64'h0);
    step(1'b1, 2'b01, 64'h42, 64'h0, 1'b0);
    chk("post_rst_pc", bus.out_pc, 64'h42);

    // Randomized traffic: fill-biased then drain-biased, rare resets.
    for (int k = 0; k < 500; k++) begin
      step(($urandom_range(149) != 0),
           2'($urandom),
           {$urandom, $urandom}, {$urandom, $urandom},
           (k < 250) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Multi-lane commit-trace collector between a superscalar core's per-lane debug commit outputs (pc, rf write number, rf write data) and a single-lane difftest/trace consumer.
- Each cycle it accepts up to COMMIT_WIDTH commit records, compacts them in lane order, and buffers them in a DEPTH-entry FIFO.
- It drains one record per handshake, so lane ordering is preserved across cycles.
- It replaces the single-lane, unbuffered debug trace path.

Parameters:
- COMMIT_WIDTH, 2: number of commit lanes presented per cycle (1..4).
- DEPTH, 16: FIFO entries. Power of two, >= 2*COMMIT_WIDTH.
- XLEN, 64: width of pc and rf write data.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  COMMIT_WIDTH  per-lane commit valid; bit i is lane i.
- in_pc  in  COMMIT_WIDTH*XLEN  lane i at bits [i*XLEN +: XLEN].
- in_rf_wnum  in  COMMIT_WIDTH*5  lane i at [i*5 +: 5]; 0 means no rf write.
- in_rf_wdata  in  COMMIT_WIDTH*XLEN  lane i at [i*XLEN +: XLEN].
- in_ready  out  1  buffer can absorb a full group this cycle.
- out_valid  out  1  head record available.
- out_ready  in  1  consumer takes the head record.
- out_pc  out  XLEN  head pc.
- out_rf_wnum  out  5  head rf write number.
- out_rf_wdata  out  XLEN  head rf write data.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky flag: a valid group was dropped.

Behaviour:
- Reset (reset==0 at a clock edge): rd_ptr=wr_ptr=0, count=0, overflow=0. Outputs follow: out_valid=0, in_ready=1. Storage contents are not cleared, but out_* data are don't-care while out_valid=0. Reset mid-operation discards all buffered records in that cycle.
- in_ready = ((DEPTH - count) >= COMMIT_WIDTH). It is computed from the registered count only and ignores a same-cycle pop, so there is no combinational path from out_ready to in_ready.
- push group = in_ready && |in_valid.
  - npush = popcount(in_valid).
  - Valid lanes are written to wr_ptr, wr_ptr+1, ... in ascending lane order, skipping invalid lanes (sparse valid is legal, e.g. 2'b10 writes lane 1 only).
  - wr_ptr advances by npush modulo DEPTH.
- Drop: |in_valid && !in_ready means the whole group is discarded and overflow is set to 1. overflow stays set until reset. No partial group is ever written.
- Output is first-word-fall-through.
  - out_valid = (count != 0). out_* reflect entry rd_ptr combinationally from storage.
  - pop = out_valid && out_ready. rd_ptr increments modulo DEPTH on pop.
  - out_ready while out_valid=0 has no effect.
- count_next = count + npush - pop. Simultaneous push and pop in one cycle are both honoured, including at count==DEPTH-COMMIT_WIDTH and at count==1.
- A record pushed in cycle N is visible on out_* at cycle N+1 at the earliest. There is no same-cycle bypass when empty.
- Pointer wrap: both pointers are $clog2(DEPTH) bits and wrap naturally. A group may straddle the wrap (entries DEPTH-1 and 0).
- out_* hold stable while out_valid && !out_ready.

Optional Feature:
- Macro: COMMIT_TRACE_SRAM_EN.
- When defined:
  - Adds inputs in_sram_wen (COMMIT_WIDTH*8), in_sram_waddr (COMMIT_WIDTH*32) and in_sram_wdata (COMMIT_WIDTH*64).
  - Adds outputs out_sram_wen (8), out_sram_waddr (32) and out_sram_wdata (64).
  - These fields are stored per entry and travel with the record under identical compaction, ordering and drop rules.
- When undefined: these ports and their storage do not exist. All other behaviour is unchanged.

Test Plan:
1. Reset release, in_valid=0 -> out_valid=0, count=0, in_ready=1, overflow=0. Hold out_ready=1 for 5 cycles -> count stays 0.
2. COMMIT_WIDTH=2, one cycle in_valid=2'b11 with pc0=0x80000000, pc1=0x80000004 -> next cycle count=2 and out_pc=0x80000000. Pop -> out_pc=0x80000004. Pop -> out_valid=0.
3. Sparse lanes: in_valid=2'b10 with pc1=0x1000, then 2'b01 with pc0=0x2000 -> dequeue order 0x1000, 0x2000 and count peaks at 2.
4. DEPTH=16, out_ready=0, push 2'b11 for 8 cycles -> count=16 and in_ready=0. A 9th push of 2'b01 -> overflow=1, count stays 16. Pop all -> 16 records in push order; overflow remains 1 until reset.
5. Steady state: push 1 record/cycle with out_ready=1 for 40 cycles -> count never exceeds 1, the pc sequence is preserved across pointer wrap, and no overflow occurs.
6. With count=14, assert reset=0 for one cycle while pushing 2'b11 and popping -> next cycle count=0 and out_valid=0. Then push pc=0x42 -> out_pc=0x42.
